// File: rtl/timer_event_scheduler.sv
// rtl/timer_event_scheduler.sv - multi-channel tick timer with round-robin event port
//
// One shared prescaler produces a base tick every CLOCK_FREQ_HZ/TICK_HZ clocks.
// NUM_CH channels count ticks against programmable periods (periodic or one-shot).
// Each expiry pulses o_Expire and sets a pending flag. Pending flags are drained
// one at a time through a valid/ready event port by a round-robin arbiter.
//
// Ports:
//   i_Clk          system clock
//   i_Rst_n        asynchronous active-low reset
//   i_Cfg_Wr       one-cycle config write strobe
//   i_Cfg_Ch       channel being configured
//   i_Cfg_Period   period in ticks (0 = never expires)
//   i_Cfg_Enable   channel run enable
//   i_Cfg_Oneshot  1 = one-shot, 0 = periodic
//   o_Tick         base tick pulse, one cycle
//   o_Expire       per-channel expiry pulse, one cycle
//   o_Pending      per-channel pending-event flags
//   o_Overrun      per-channel sticky lost-event flags
//   o_Evt_Valid    event available
//   o_Evt_Ch       channel of the presented event
//   i_Evt_Ready    consumer accepts the event

module timer_event_scheduler #(
  parameter int CLOCK_FREQ_HZ = 25_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int CH_W          = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Cfg_Wr,
  input  logic [CH_W-1:0]      i_Cfg_Ch,
  input  logic [CNT_W-1:0]     i_Cfg_Period,
  input  logic                 i_Cfg_Enable,
  input  logic                 i_Cfg_Oneshot,
  output logic                 o_Tick,
  output logic [2**CH_W-1:0]   o_Expire,
  output logic [2**CH_W-1:0]   o_Pending,
  output logic [2**CH_W-1:0]   o_Overrun,
  output logic                 o_Evt_Valid,
  output logic [CH_W-1:0]      o_Evt_Ch,
  input  logic                 i_Evt_Ready
);

  localparam int NUM_CH   = 2**CH_W;
  localparam int PRESCALE = CLOCK_FREQ_HZ / TICK_HZ;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // Prescaler: tick is registered, so it is high in the cycle after the count
  // reaches PRESCALE-1, giving one pulse every PRESCALE clocks.
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;

  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    tick_d = (ps_q == PS_LAST);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] os_q, os_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [NUM_CH-1:0] exp_q, exp_d;

  // Arbiter state
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   last_q, last_d;

  logic              accept;
  logic [NUM_CH-1:0] accept_mask;

  always_comb begin
    accept              = valid_q & i_Evt_Ready;
    accept_mask         = '0;
    accept_mask[ch_q]   = accept;
  end

  // Channel next-state. A config write to a channel takes priority over a tick
  // arriving in the same cycle, so that channel does not advance.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
    end
    en_d  = en_q;
    os_d  = os_q;
    ovr_d = ovr_q;
    exp_d = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (i_Cfg_Wr && (i_Cfg_Ch == CH_W'(i))) begin
        period_d[i] = i_Cfg_Period;
        en_d[i]     = i_Cfg_Enable;
        os_d[i]     = i_Cfg_Oneshot;
        cnt_d[i]    = '0;
        ovr_d[i]    = 1'b0;
      end else if (tick_q && en_q[i] && (period_q[i] != '0)) begin
        if (cnt_q[i] == period_q[i] - 1'b1) begin
          cnt_d[i] = '0;
          exp_d[i] = 1'b1;
          if (os_q[i]) begin
            en_d[i] = 1'b0;
          end
          // An event is lost only if the old one is still waiting and is not
          // leaving through the port on this very edge.
          if (pend_q[i] && !accept_mask[i]) begin
            ovr_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    // A new expiry re-sets pending even when the old event is accepted now.
    pend_d = (pend_q & ~accept_mask) | exp_d;
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection: first pending channel after the last grant.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_q + CH_W'(k);
      if (!found && pend_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // After a transfer valid drops for one cycle, so the next selection sees the
  // cleared pending flag and the updated grant pointer.
  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (accept) begin
      valid_d = 1'b0;
      last_d  = ch_q;
    end else if (!valid_q && found) begin
      valid_d = 1'b1;
      ch_d    = pick;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      en_q    <= '0;
      os_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      en_q    <= en_d;
      os_q    <= os_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      exp_q   <= exp_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign o_Tick      = tick_q;
  assign o_Expire    = exp_q;
  assign o_Pending   = pend_q;
  assign o_Overrun   = ovr_q;
  assign o_Evt_Valid = valid_q;
  assign o_Evt_Ch    = ch_q;

endmodule

// File: tb/tb_timer_event_scheduler.sv
// tb/tb_timer_event_scheduler.sv - scoreboard bench for timer_event_scheduler

module tb_timer_event_scheduler;

  localparam int P   = 10;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_enable;
  logic        cfg_oneshot;
  logic        evt_ready;
  logic        tick;
  logic [3:0]  expire;
  logic [3:0]  pending;
  logic [3:0]  overrun;
  logic        evt_valid;
  logic [1:0]  evt_ch;

  timer_event_scheduler #(
    .CLOCK_FREQ_HZ(100),
    .TICK_HZ(10),
    .CH_W(2),
    .CNT_W(16)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Cfg_Wr(cfg_wr),
    .i_Cfg_Ch(cfg_ch),
    .i_Cfg_Period(cfg_period),
    .i_Cfg_Enable(cfg_enable),
    .i_Cfg_Oneshot(cfg_oneshot),
    .o_Tick(tick),
    .o_Expire(expire),
    .o_Pending(pending),
    .o_Overrun(overrun),
    .o_Evt_Valid(evt_valid),
    .o_Evt_Ch(evt_ch),
    .i_Evt_Ready(evt_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: clocks since reset decide the tick, each channel counts
  // ticks since its last configuration, events are served in rotating order.
  // ---------------------------------------------------------------------------
  int       m_per   [NCH] = '{0, 0, 0, 0};
  int       m_ticks [NCH] = '{0, 0, 0, 0};
  bit [3:0] m_en   = '0;
  bit [3:0] m_os   = '0;
  bit [3:0] m_pend = '0;
  bit [3:0] m_ovr  = '0;
  bit [3:0] m_exp  = '0;
  bit       m_tick = 1'b0;
  bit       m_valid = 1'b0;
  int       m_ch   = 0;
  int       m_last = NCH - 1;
  int       edge_n = 0;
  int       exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_per[i]   = 0;
      m_ticks[i] = 0;
    end
    m_en = '0; m_os = '0; m_pend = '0; m_ovr = '0; m_exp = '0;
    m_tick = 1'b0; m_valid = 1'b0; m_ch = 0; m_last = NCH - 1;
    edge_n = 0;
    exp_q.delete();
  endfunction

  initial begin
    bit       acc;
    bit [3:0] taken;
    bit [3:0] old_pend;
    int       c;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        acc      = m_valid && evt_ready;
        taken    = '0;
        if (acc) taken[m_ch] = 1'b1;
        old_pend = m_pend;
        m_exp    = '0;
        for (int i = 0; i < NCH; i++) begin
          if (cfg_wr && cfg_ch == i) begin
            m_per[i]   = int'(cfg_period);
            m_en[i]    = cfg_enable;
            m_os[i]    = cfg_oneshot;
            m_ticks[i] = 0;
            m_ovr[i]   = 1'b0;
          end else if (m_tick && m_en[i] && m_per[i] != 0) begin
            m_ticks[i]++;
            if (m_ticks[i] == m_per[i]) begin
              m_ticks[i] = 0;
              m_exp[i]   = 1'b1;
              if (m_os[i]) m_en[i] = 1'b0;
              if (old_pend[i] && !taken[i]) m_ovr[i] = 1'b1;
            end
          end
        end
        m_pend = (old_pend & ~taken) | m_exp;
        if (acc) begin
          m_valid = 1'b0;
          m_last  = m_ch;
        end else if (!m_valid && old_pend != 0) begin
          c = 0;
          for (int k = 1; k <= NCH; k++) begin
            c = (m_last + k) % NCH;
            if (old_pend[c]) break;
          end
          m_valid = 1'b1;
          m_ch    = c;
          exp_q.push_back(c);
        end
        edge_n++;
        m_tick = (edge_n % P == 0);
      end
    end
  end

  // Monitor: compares every cycle away from the active edge and pops the
  // scoreboard each time a new event is presented.
  initial begin
    bit pv;
    int e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      chk("tick", int'(tick), int'(m_tick));
      chk("expire", int'(expire), int'(m_exp));
      chk("pending", int'(pending), int'(m_pend));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("evt_valid", int'(evt_valid), int'(m_valid));
      if (m_valid) chk("evt_ch", int'(evt_ch), m_ch);
      if (evt_valid && !pv) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_event actual_ch=%0d expected=none at %0t", evt_ch, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_evt_ch", int'(evt_ch), e);
        end
      end
      pv = evt_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int ch, input int per, input bit en, input bit os);
    cyc();
    cfg_wr      = 1'b1;
    cfg_ch      = ch[1:0];
    cfg_period  = per[15:0];
    cfg_enable  = en;
    cfg_oneshot = os;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 25);
    if (!tick) begin
      total++;
      bad++;
      $display("FAIL wait_tick_timeout actual=no_tick expected=tick at %0t", $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int got;
    int grants[3];
    int n;

    rst_n       = 1'b0;
    cfg_wr      = 1'b0;
    cfg_ch      = '0;
    cfg_period  = '0;
    cfg_enable  = 1'b0;
    cfg_oneshot = 1'b0;
    evt_ready   = 1'b0;
    #22;
    rst_n = 1'b1;

    // Idle: four ticks in 40 clocks, nothing else.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (tick) cnt++;
    end
    chk("idle_tick_count", cnt, 4);

    // ch1 periodic, period 3: three expiries over ten ticks.
    evt_ready = 1'b1;
    cfg(1, 3, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (expire[1]) cnt++;
    end
    chk("ch1_expire_count", cnt, 3);

    // ch2 one-shot, period 2: a single expiry over 100 ticks.
    cfg(2, 2, 1'b1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (expire[2]) cnt++;
    end
    chk("ch2_oneshot_count", cnt, 1);

    // Fresh start so channel 0 wins first, then overrun with consumer stalled.
    evt_ready = 1'b0;
    do_reset();
    cfg(0, 1, 1'b1, 1'b0);
    cfg(1, 1, 1'b1, 1'b0);
    cfg(3, 1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) cyc();
    chk("stall_valid", int'(evt_valid), 1);
    chk("stall_ch", int'(evt_ch), 0);
    chk("stall_overrun", int'(overrun & 4'b1011), 4'b1011);
    evt_ready = 1'b1;
    got = 0;
    n   = 0;
    while (got < 3 && n < 20) begin
      if (evt_valid) begin
        grants[got] = int'(evt_ch);
        got++;
      end
      cyc();
      n++;
    end
    chk("grant_count", got, 3);
    chk("grant0", grants[0], 0);
    chk("grant1", grants[1], 1);
    chk("grant2", grants[2], 3);

    // Accept on the same edge as a new expiry: pending stays, no overrun.
    cfg(1, 0, 1'b0, 1'b0);
    cfg(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) cyc();
    cfg(0, 1, 1'b1, 1'b0);
    wait_tick();
    cyc();
    evt_ready = 1'b0;
    wait_tick();
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("same_edge_pending0", int'(pending[0]), 1);
    chk("same_edge_overrun0", int'(overrun[0]), 0);
    chk("same_edge_gap", int'(evt_valid), 0);
    cyc();
    chk("same_edge_reissue", int'(evt_valid), 1);
    chk("same_edge_ch", int'(evt_ch), 0);

    // Randomized configuration and back-pressure.
    for (int i = 0; i < 800; i++) begin
      cyc();
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0) begin
        cfg_wr      = 1'b1;
        cfg_ch      = 2'($urandom_range(0, 3));
        cfg_period  = 16'($urandom_range(0, 4));
        cfg_enable  = ($urandom_range(0, 3) != 0);
        cfg_oneshot = ($urandom_range(0, 2) == 0);
      end else begin
        cfg_wr = 1'b0;
      end
    end
    cyc();
    cfg_wr = 1'b0;

    // Reset while an event is on the port; nothing may follow it.
    evt_ready = 1'b0;
    cfg(3, 1, 1'b1, 1'b0);
    n = 0;
    while (!evt_valid && n < 30) begin
      cyc();
      n++;
    end
    chk("pre_reset_valid", int'(evt_valid), 1);
    do_reset();
    evt_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (evt_valid || pending != 0 || expire != 0) cnt++;
    end
    chk("post_reset_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
